// File: rtl/tpu_pkg.sv
// Shared types and sizing constants for the 2x2 systolic array datapath.
// The feeder's counter widths are derived here from the array size.
package tpu_pkg;

   localparam int ARR_N         = 2;
   localparam int OPERAND_BYTES = 2 * ARR_N * ARR_N;
   localparam int ISSUE_STEPS   = ARR_N * ARR_N;
   localparam int LOAD_CNT_W    = $clog2(OPERAND_BYTES);
   localparam int ISSUE_CNT_W   = $clog2(ISSUE_STEPS);
   localparam int DRAIN_CNT_W   = 4;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/operand_buffer_2x2.sv
// Eight-entry operand register file: entries 0..3 hold A, 4..7 hold B.
// One write port indexed by the load counter, two combinational read ports at issue step t.
import tpu_pkg::*;

module operand_buffer_2x2 #(
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_wr_en,
   input  logic [LOAD_CNT_W-1:0]  i_wr_idx,
   input  logic [WIDTH-1:0]       i_wr_data,
   input  logic [ISSUE_CNT_W-1:0] i_rd_t,
   output logic [WIDTH-1:0]       o_a_data,
   output logic [WIDTH-1:0]       o_b_data
);

   logic [WIDTH-1:0] r_mem [OPERAND_BYTES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < OPERAND_BYTES; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   // A[i][k] and B[i][k] both sit at offset t = {i,k} within their half.
   assign o_a_data = r_mem[{1'b0, i_rd_t}];
   assign o_b_data = r_mem[{1'b1, i_rd_t}];

endmodule

// File: rtl/matrix_feeder_2x2.sv
// Operand loader/sequencer for the 2x2 systolic array: buffers eight bytes,
// issues them over four cycles, waits DRAIN cycles, then pulses done.
import tpu_pkg::*;

module matrix_feeder_2x2 #(
   parameter int WIDTH = 8,
   parameter int DRAIN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] a_data,
   output logic [WIDTH-1:0] b_data,
   output logic [1:0]       a_row_idx,
   output logic [1:0]       b_col_idx,
   output logic             valid_in,
   output logic             busy,
   output logic             done
);

   feeder_state_t          r_state;
   logic [LOAD_CNT_W-1:0]  r_load_cnt;
   logic [ISSUE_CNT_W-1:0] r_issue_cnt;
   logic [DRAIN_CNT_W-1:0] r_drain_cnt;
   logic [WIDTH-1:0]       r_a_data;
   logic [WIDTH-1:0]       r_b_data;
   logic [1:0]             r_a_row_idx;
   logic [1:0]             r_b_col_idx;
   logic                   r_valid_in;
   logic                   r_busy;
   logic                   r_done;

   logic                   w_load_hs;
   logic [ISSUE_CNT_W-1:0] w_rd_t;
   logic [WIDTH-1:0]       w_a_rd;
   logic [WIDTH-1:0]       w_b_rd;

   assign in_ready  = (r_state == ST_LOAD);
   assign w_load_hs = in_valid & in_ready;

   // Outputs are registered one step ahead: entering ISSUE registers t=0,
   // and each ISSUE cycle registers the step after the one on display.
   assign w_rd_t = (r_state == ST_ISSUE) ? (r_issue_cnt + ISSUE_CNT_W'(1)) : '0;

   operand_buffer_2x2 #(
      .WIDTH (WIDTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .i_wr_en   (w_load_hs),
      .i_wr_idx  (r_load_cnt),
      .i_wr_data (in_data),
      .i_rd_t    (w_rd_t),
      .o_a_data  (w_a_rd),
      .o_b_data  (w_b_rd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_LOAD;
         r_load_cnt  <= '0;
         r_issue_cnt <= '0;
         r_drain_cnt <= '0;
         r_a_data    <= '0;
         r_b_data    <= '0;
         r_a_row_idx <= '0;
         r_b_col_idx <= '0;
         r_valid_in  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_load_hs) begin
                  if (r_load_cnt == LOAD_CNT_W'(OPERAND_BYTES - 1)) begin
                     r_load_cnt  <= '0;
                     r_issue_cnt <= '0;
                     r_state     <= ST_ISSUE;
                     r_busy      <= 1'b1;
                     r_valid_in  <= 1'b1;
                     r_a_data    <= w_a_rd;
                     r_b_data    <= w_b_rd;
                     r_a_row_idx <= {1'b0, w_rd_t[1]};
                     r_b_col_idx <= {1'b0, w_rd_t[0]};
                  end else begin
                     r_load_cnt <= r_load_cnt + LOAD_CNT_W'(1);
                  end
               end
            end
            ST_ISSUE: begin
               if (r_issue_cnt == ISSUE_CNT_W'(ISSUE_STEPS - 1)) begin
                  r_state     <= ST_DRAIN;
                  r_drain_cnt <= '0;
                  r_valid_in  <= 1'b0;
                  r_a_data    <= '0;
                  r_b_data    <= '0;
                  r_a_row_idx <= '0;
                  r_b_col_idx <= '0;
               end else begin
                  r_issue_cnt <= r_issue_cnt + ISSUE_CNT_W'(1);
                  r_a_data    <= w_a_rd;
                  r_b_data    <= w_b_rd;
                  r_a_row_idx <= {1'b0, w_rd_t[1]};
                  r_b_col_idx <= {1'b0, w_rd_t[0]};
               end
            end
            ST_DRAIN: begin
               if (r_drain_cnt == DRAIN_CNT_W'(DRAIN - 1)) begin
                  r_drain_cnt <= '0;
                  r_state     <= ST_DONE;
                  r_done      <= 1'b1;
               end else begin
                  r_drain_cnt <= r_drain_cnt + DRAIN_CNT_W'(1);
               end
            end
            ST_DONE: begin
               r_state <= ST_LOAD;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= ST_LOAD;
            end
         endcase
      end
   end

   assign a_data    = r_a_data;
   assign b_data    = r_b_data;
   assign a_row_idx = r_a_row_idx;
   assign b_col_idx = r_b_col_idx;
   assign valid_in  = r_valid_in;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_matrix_feeder_2x2.sv
// Bench for matrix_feeder_2x2: table of load/issue jobs on a DRAIN=4 instance,
// plus reset and back-to-back sequences, the latter on a DRAIN=1 instance.
module tb_matrix_feeder_2x2;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;

   logic       d0_in_ready, d0_valid_in, d0_busy, d0_done;
   logic [7:0] d0_a_data, d0_b_data;
   logic [1:0] d0_a_row_idx, d0_b_col_idx;
   logic       d1_in_ready, d1_valid_in, d1_busy, d1_done;
   logic [7:0] d1_a_data, d1_b_data;
   logic [1:0] d1_a_row_idx, d1_b_col_idx;

   matrix_feeder_2x2 #(.WIDTH(8), .DRAIN(4)) dut0 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (d0_in_ready),
      .a_data    (d0_a_data),
      .b_data    (d0_b_data),
      .a_row_idx (d0_a_row_idx),
      .b_col_idx (d0_b_col_idx),
      .valid_in  (d0_valid_in),
      .busy      (d0_busy),
      .done      (d0_done)
   );

   matrix_feeder_2x2 #(.WIDTH(8), .DRAIN(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (d1_in_ready),
      .a_data    (d1_a_data),
      .b_data    (d1_b_data),
      .a_row_idx (d1_a_row_idx),
      .b_col_idx (d1_b_col_idx),
      .valid_in  (d1_valid_in),
      .busy      (d1_busy),
      .done      (d1_done)
   );

   always #5 clk = ~clk;

   // Observation word: {valid_in, busy, done, in_ready, a_row_idx, b_col_idx, a_data, b_data}
   logic [23:0] obs0, obs1;
   assign obs0 = {d0_valid_in, d0_busy, d0_done, d0_in_ready, d0_a_row_idx, d0_b_col_idx, d0_a_data, d0_b_data};
   assign obs1 = {d1_valid_in, d1_busy, d1_done, d1_in_ready, d1_a_row_idx, d1_b_col_idx, d1_a_data, d1_b_data};

   localparam logic [23:0] OBS_IDLE  = 24'h100000;
   localparam logic [23:0] OBS_DRAIN = 24'h400000;
   localparam logic [23:0] OBS_DONE  = 24'h600000;

   typedef struct packed {
      logic [7:0][7:0] bytes;
      logic            throttle;
      logic            hold_ff;
      logic [3:0][7:0] ea;
      logic [3:0][7:0] eb;
   } vec_t;

   vec_t vecs [5];
   int   n_vec  = 0;
   int   n_fail = 0;

   function automatic logic [23:0] obs(input int sel);
      return (sel != 0) ? obs1 : obs0;
   endfunction

   task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %06h expected %06h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input int sel, input logic [7:0] d, input logic gap);
      int          n;
      logic [23:0] o;
      if (gap) begin
         in_valid = 1'b0;
         in_data  = 8'hEE;
         step();
      end
      in_valid = 1'b1;
      in_data  = d;
      n = 0;
      o = obs(sel);
      while (o[20] !== 1'b1 && n < 50) begin
         step();
         n++;
         o = obs(sel);
      end
      if (n >= 50) begin
         n_vec++;
         n_fail++;
         $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
      end
      step();
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic load_job(input int sel, input logic [7:0][7:0] bytes, input logic throttle);
      for (int i = 0; i < 8; i++) begin
         send_byte(sel, bytes[i], throttle);
      end
   endtask

   // Called one cycle after the byte-7 handshake; ends in the first LOAD cycle.
   task automatic check_job(input string name, input int sel, input int drain,
                            input logic [3:0][7:0] ea, input logic [3:0][7:0] eb,
                            input logic hold_ff);
      logic [1:0]  exp_row [4];
      logic [1:0]  exp_col [4];
      logic [23:0] exp;
      exp_row = '{2'd0, 2'd0, 2'd1, 2'd1};
      exp_col = '{2'd0, 2'd1, 2'd0, 2'd1};
      for (int k = 0; k <= 5 + drain; k++) begin
         if (k < 4)               exp = {4'b1100, exp_row[k], exp_col[k], ea[k], eb[k]};
         else if (k < 4 + drain)  exp = OBS_DRAIN;
         else if (k == 4 + drain) exp = OBS_DONE;
         else                     exp = OBS_IDLE;
         if (hold_ff && k < 5 + drain) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
         end else begin
            in_valid = 1'b0;
            in_data  = 8'h00;
         end
         chk($sformatf("%s cyc%0d", name, k), obs(sel), exp);
         if (k < 5 + drain) step();
      end
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0].bytes = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
      vecs[0].throttle = 1'b0; vecs[0].hold_ff = 1'b0;
      vecs[0].ea = {8'h04, 8'h03, 8'h02, 8'h01};
      vecs[0].eb = {8'h08, 8'h07, 8'h06, 8'h05};

      vecs[1].bytes = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
      vecs[1].throttle = 1'b1; vecs[1].hold_ff = 1'b0;
      vecs[1].ea = {8'h04, 8'h03, 8'h02, 8'h01};
      vecs[1].eb = {8'h08, 8'h07, 8'h06, 8'h05};

      vecs[2].bytes = {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
      vecs[2].throttle = 1'b0; vecs[2].hold_ff = 1'b1;
      vecs[2].ea = {8'h44, 8'h33, 8'h22, 8'h11};
      vecs[2].eb = {8'h88, 8'h77, 8'h66, 8'h55};

      vecs[3].bytes = {8'h3C, 8'hC3, 8'hFE, 8'h01, 8'h7F, 8'h80, 8'h00, 8'h5A};
      vecs[3].throttle = 1'b1; vecs[3].hold_ff = 1'b1;
      vecs[3].ea = {8'h7F, 8'h80, 8'h00, 8'h5A};
      vecs[3].eb = {8'h3C, 8'hC3, 8'hFE, 8'h01};

      vecs[4].bytes = {8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10};
      vecs[4].throttle = 1'b0; vecs[4].hold_ff = 1'b0;
      vecs[4].ea = {8'h40, 8'h30, 8'h20, 8'h10};
      vecs[4].eb = {8'h80, 8'h70, 8'h60, 8'h50};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) step();
      rst = 1'b0;
      #1;
      chk("reset dut0", obs0, OBS_IDLE);
      chk("reset dut1", obs1, OBS_IDLE);

      for (int v = 0; v < 5; v++) begin
         load_job(0, vecs[v].bytes, vecs[v].throttle);
         check_job($sformatf("vec%0d", v), 0, 4, vecs[v].ea, vecs[v].eb, vecs[v].hold_ff);
      end

      // Reset while t=2 is on the outputs, then again with a partial load pending.
      load_job(0, vecs[0].bytes, 1'b0);
      step();
      step();
      chk("pre-rst t2", obs0, {4'b1100, 2'd1, 2'd0, 8'h03, 8'h07});
      rst = 1'b1;
      #1;
      chk("async rst mid-issue", obs0, OBS_IDLE);
      #1;
      rst = 1'b0;
      send_byte(0, 8'hE1, 1'b0);
      send_byte(0, 8'hE2, 1'b0);
      send_byte(0, 8'hE3, 1'b0);
      chk("partial load still idle", obs0, OBS_IDLE);
      pulse_rst();
      load_job(0, {8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10, 8'h09}, 1'b0);
      check_job("post-rst", 0, 4, {8'h12, 8'h11, 8'h10, 8'h09}, {8'h16, 8'h15, 8'h14, 8'h13}, 1'b0);

      // DRAIN=1 instance: done 6 cycles after byte 8, next job starts right after done.
      pulse_rst();
      step();
      load_job(1, vecs[0].bytes, 1'b0);
      check_job("d1 job1", 1, 1, vecs[0].ea, vecs[0].eb, 1'b0);
      load_job(1, {8'h28, 8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21}, 1'b0);
      check_job("d1 job2", 1, 1, {8'h24, 8'h23, 8'h22, 8'h21}, {8'h28, 8'h27, 8'h26, 8'h25}, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/matrix_feeder_2x2.md
# matrix_feeder_2x2

Operand loader and sequencer that sits directly upstream of the 2x2 systolic array. It accepts the eight 8-bit operands of a 2x2 by 2x2 product as a byte stream with a valid/ready handshake and buffers them. It then drives the array's `a_data`/`b_data`/`a_row_idx`/`b_col_idx`/`valid_in` inputs with a fixed four-cycle issue schedule, waits a programmable drain interval, and pulses `done`.

## Interface
Parameters:
- `WIDTH`, 8: operand width; must match the array's `WIDTH`.
- `DRAIN`, 4: idle cycles after the last issue before `done`; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_data`  in  WIDTH  operand byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  feeder accepts a byte this cycle.
- `a_data`  out  WIDTH  to array `a_data`.
- `b_data`  out  WIDTH  to array `b_data`.
- `a_row_idx`  out  2  to array `a_row_idx`.
- `b_col_idx`  out  2  to array `b_col_idx`.
- `valid_in`  out  1  to array `valid_in`.
- `busy`  out  1  state is ISSUE, DRAIN or DONE.
- `done`  out  1  one-cycle pulse when the result is settled.

## Operation
- Load order is fixed: A00, A01, A10, A11, B00, B01, B10, B11.
  - These are byte indices 0..7.
  - Indices 0..3 go to the A buffer and 4..7 to the B buffer.
- FSM states: LOAD, ISSUE, DRAIN, DONE.
  - **LOAD:** `in_ready`=1. Each handshake (`in_valid & in_ready`) writes the byte at `load_cnt` and increments `load_cnt`. The handshake at `load_cnt`=7 moves the FSM to ISSUE and resets `load_cnt` to 0.
  - **ISSUE:** `issue_cnt` t runs 0..3, one step per cycle.
    - i = t[1] and k = t[0].
    - `a_data` = A[i][k] and `a_row_idx` = {1'b0, i}.
    - `b_data` = B[i][k] and `b_col_idx` = {1'b0, k}.
    - `valid_in` = 1.
    - After t=3 the FSM moves to DRAIN.
  - **DRAIN:** `valid_in`=0. `drain_cnt` counts `DRAIN` cycles, then the FSM moves to DONE.
  - **DONE:** `done`=1 for exactly one cycle, then the FSM returns to LOAD. `busy` stays 1 in DONE.
- `in_ready`=0 in every state except LOAD. Bytes offered outside LOAD are ignored and not queued.
- When `valid_in`=0, `a_data`, `b_data`, `a_row_idx` and `b_col_idx` are all driven to 0.
- The upper bit of `a_row_idx` and `b_col_idx` is always 0.
- Buffered operands persist across DONE. They are overwritten only by the next load.

## Timing
- Reset values: state LOAD, all counters 0, buffers 0. `in_ready`=1; every other output is 0.
- Reset asserted mid-ISSUE or mid-DRAIN:
  - `valid_in` and all data outputs drop to 0 asynchronously.
  - Partially loaded bytes are discarded, and loading restarts at index 0.
- All outputs except `in_ready` come from registers. `in_ready` is a decode of the state register only; it never depends on `in_valid`.
- Latency:
  - The handshake on byte 7 happens at edge N.
  - `valid_in` is high for edges N+1..N+4, carrying t=0..3.
  - `valid_in` is low for the following `DRAIN` cycles.
  - `done` is high in the single cycle after the drain.
  - Total cycles from the byte-7 handshake to `done`: 4 + `DRAIN` + 1.
- `in_valid` gaps during LOAD stall loading without limit. There is no timeout.
- `done` and `in_ready` are never high in the same cycle. `in_ready` rises in the cycle after `done`.
- Back-to-back jobs: the first byte of the next job can be accepted in the cycle after `done`.

## Structure
- Shared package `tpu_pkg` holds:
  - the `feeder_state_t` enum (LOAD, ISSUE, DRAIN, DONE);
  - `ARR_N`=2;
  - `OPERAND_BYTES`=8;
  - the counter widths derived from these.
- One sub-module: `operand_buffer_2x2`.
  - An 8-entry, `WIDTH`-bit register file.
  - One write port, indexed by `load_cnt`.
  - Two combinational read ports, A[t] and B[t].
- The FSM, counters and output registers live in `matrix_feeder_2x2`.

## Test plan
- **Load then issue.** Bytes 1,2,3,4,5,6,7,8 are sent with `in_valid` held high. Required response:
  - `in_ready` drops after byte 8.
  - Four `valid_in` cycles follow, each as (`a_data`, `a_row_idx`, `b_data`, `b_col_idx`): (1,0,5,0), (2,0,6,1), (3,1,7,0), (4,1,8,1).
  - `done` pulses 4+4+1=9 cycles after the byte-8 handshake.
- **Throttled input.** Same bytes, with `in_valid` toggling 1/0. Required response: identical issue sequence; no byte is skipped or duplicated.
- **Ignored bytes while busy.** `in_valid`=1 with value 0xFF is held through ISSUE, DRAIN and DONE. Required response:
  - `in_ready`=0 throughout.
  - The next job loads only bytes presented from LOAD onward.
- **Reset mid-ISSUE.** `rst` is pulsed during t=2. Required response:
  - `valid_in`, data and `busy` are 0 immediately.
  - `in_ready`=1.
  - A fresh 8-byte load issues correctly.
- **`DRAIN`=1, back-to-back jobs.** `done` arrives 6 cycles after byte 8. Byte 0 of job 2 is accepted in the cycle after `done`.
- **Zero-data check.** In all non-ISSUE cycles, `a_data`, `b_data`, `a_row_idx` and `b_col_idx` are exactly 0.
